// File: rtl/gate_delay_pkg.sv
// Shared types and reset constants for the gate delay meter.
// Optional min/max tracking is enabled by defining GATE_DELAY_MINMAX_EN.
package gate_delay_pkg;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } state_e;

   typedef enum logic [0:0] {
      RISE = 1'b0,
      FALL = 1'b1
   } cls_e;

   // Wide constants; users cast them down to their counter width
   localparam logic [31:0] MIN_INIT = '1;
   localparam logic [31:0] MAX_INIT = '0;

endpackage

// File: rtl/gate_delay_meter_if.sv
// Stimulus/response and result bus of the gate delay meter.
// Min/max result signals exist only when GATE_DELAY_MINMAX_EN is defined.
interface gate_delay_meter_if #(
   parameter int unsigned CNT_W = 8
);
   logic             stim;
   logic             resp;
   logic             clr;
   logic             busy;
   logic [CNT_W-1:0] rise_dly;
   logic [CNT_W-1:0] fall_dly;
   logic             rise_vld;
   logic             fall_vld;
   logic             timeout;
   logic             abort;
`ifdef GATE_DELAY_MINMAX_EN
   logic [CNT_W-1:0] min_rise;
   logic [CNT_W-1:0] max_rise;
   logic [CNT_W-1:0] min_fall;
   logic [CNT_W-1:0] max_fall;

   modport master (
      output stim, resp, clr,
      input  busy, rise_dly, fall_dly, rise_vld, fall_vld, timeout, abort,
      input  min_rise, max_rise, min_fall, max_fall
   );

   modport slave (
      input  stim, resp, clr,
      output busy, rise_dly, fall_dly, rise_vld, fall_vld, timeout, abort,
      output min_rise, max_rise, min_fall, max_fall
   );
`else
   modport master (
      output stim, resp, clr,
      input  busy, rise_dly, fall_dly, rise_vld, fall_vld, timeout, abort
   );

   modport slave (
      input  stim, resp, clr,
      output busy, rise_dly, fall_dly, rise_vld, fall_vld, timeout, abort
   );
`endif
endinterface

// File: rtl/gate_delay_edge.sv
// Stimulus edge detector; the first cycle after reset only primes the history
// so a stim held high through reset never looks like an edge.
module gate_delay_edge #(
   parameter bit INVERT = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic stim_i,
   output logic stim_edge_c,
   output logic target_c
);

   logic stim_q;
   logic primed_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stim_q   <= 1'b0;
         primed_q <= 1'b0;
      end else begin
         stim_q   <= stim_i;
         primed_q <= 1'b1;
      end
   end

   assign stim_edge_c = primed_q & (stim_i ^ stim_q);
   assign target_c    = stim_i ^ INVERT;

endmodule

// File: rtl/gate_delay_meter.sv
// Measures DUT rise/fall propagation delay in clock cycles from stim/resp.
// Define GATE_DELAY_MINMAX_EN to add running min/max per transition class.
module gate_delay_meter
   import gate_delay_pkg::*;
#(
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned TIMEOUT = 200,
   parameter bit          INVERT  = 1'b0
) (
   input logic               clk,
   input logic               rst_n,
   gate_delay_meter_if.slave bus
);

   logic stim_edge_c;
   logic target_c;

   state_e           state_q,    state_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic             target_q,   target_d;
   logic [CNT_W-1:0] rise_dly_q, rise_dly_d;
   logic [CNT_W-1:0] fall_dly_q, fall_dly_d;
   logic             rise_vld_q, rise_vld_d;
   logic             fall_vld_q, fall_vld_d;
   logic             timeout_q,  timeout_d;
   logic             abort_q,    abort_d;
   logic             busy_q,     busy_d;
`ifdef GATE_DELAY_MINMAX_EN
   logic [CNT_W-1:0] min_rise_q, min_rise_d;
   logic [CNT_W-1:0] max_rise_q, max_rise_d;
   logic [CNT_W-1:0] min_fall_q, min_fall_d;
   logic [CNT_W-1:0] max_fall_q, max_fall_d;
`endif

   logic             pub_c;
   cls_e             pub_cls_c;
   logic [CNT_W-1:0] pub_val_c;

   gate_delay_edge #(
      .INVERT (INVERT)
   ) u_edge (
      .clk         (clk),
      .rst_n       (rst_n),
      .stim_i      (bus.stim),
      .stim_edge_c (stim_edge_c),
      .target_c    (target_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         target_q   <= 1'b0;
         rise_dly_q <= '0;
         fall_dly_q <= '0;
         rise_vld_q <= 1'b0;
         fall_vld_q <= 1'b0;
         timeout_q  <= 1'b0;
         abort_q    <= 1'b0;
         busy_q     <= 1'b0;
`ifdef GATE_DELAY_MINMAX_EN
         min_rise_q <= CNT_W'(MIN_INIT);
         max_rise_q <= CNT_W'(MAX_INIT);
         min_fall_q <= CNT_W'(MIN_INIT);
         max_fall_q <= CNT_W'(MAX_INIT);
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         target_q   <= target_d;
         rise_dly_q <= rise_dly_d;
         fall_dly_q <= fall_dly_d;
         rise_vld_q <= rise_vld_d;
         fall_vld_q <= fall_vld_d;
         timeout_q  <= timeout_d;
         abort_q    <= abort_d;
         busy_q     <= busy_d;
`ifdef GATE_DELAY_MINMAX_EN
         min_rise_q <= min_rise_d;
         max_rise_q <= max_rise_d;
         min_fall_q <= min_fall_d;
         max_fall_q <= max_fall_d;
`endif
      end
   end

   // Next state, counter and result update; clr dominates everything
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      target_d   = target_q;
      rise_dly_d = rise_dly_q;
      fall_dly_d = fall_dly_q;
      rise_vld_d = 1'b0;
      fall_vld_d = 1'b0;
      timeout_d  = 1'b0;
      abort_d    = 1'b0;
      pub_c      = 1'b0;
      pub_cls_c  = RISE;
      pub_val_c  = '0;
`ifdef GATE_DELAY_MINMAX_EN
      min_rise_d = min_rise_q;
      max_rise_d = max_rise_q;
      min_fall_d = min_fall_q;
      max_fall_d = max_fall_q;
`endif

      if (bus.clr) begin
         state_d    = IDLE;
         cnt_d      = '0;
         rise_dly_d = '0;
         fall_dly_d = '0;
`ifdef GATE_DELAY_MINMAX_EN
         min_rise_d = CNT_W'(MIN_INIT);
         max_rise_d = CNT_W'(MAX_INIT);
         min_fall_d = CNT_W'(MIN_INIT);
         max_fall_d = CNT_W'(MAX_INIT);
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (stim_edge_c) begin
                  target_d = target_c;
                  if (bus.resp == target_c) begin
                     pub_c     = 1'b1;
                     pub_cls_c = target_c ? RISE : FALL;
                  end else begin
                     cnt_d   = CNT_W'(1);
                     state_d = MEASURE;
                  end
               end
            end
            MEASURE: begin
               if (stim_edge_c) begin
                  abort_d  = 1'b1;
                  target_d = target_c;
                  cnt_d    = CNT_W'(1);
                  if (bus.resp == target_c) begin
                     pub_c     = 1'b1;
                     pub_cls_c = target_c ? RISE : FALL;
                     state_d   = IDLE;
                  end
               end else if (bus.resp == target_q) begin
                  pub_c     = 1'b1;
                  pub_cls_c = target_q ? RISE : FALL;
                  pub_val_c = cnt_q;
                  state_d   = IDLE;
               end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                  timeout_d = 1'b1;
                  state_d   = IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (pub_c) begin
         if (pub_cls_c == RISE) begin
            rise_dly_d = pub_val_c;
            rise_vld_d = 1'b1;
`ifdef GATE_DELAY_MINMAX_EN
            if (pub_val_c < min_rise_q) min_rise_d = pub_val_c;
            if (pub_val_c > max_rise_q) max_rise_d = pub_val_c;
`endif
         end else begin
            fall_dly_d = pub_val_c;
            fall_vld_d = 1'b1;
`ifdef GATE_DELAY_MINMAX_EN
            if (pub_val_c < min_fall_q) min_fall_d = pub_val_c;
            if (pub_val_c > max_fall_q) max_fall_d = pub_val_c;
`endif
         end
      end

      busy_d = (state_d == MEASURE);
   end

   assign bus.busy     = busy_q;
   assign bus.rise_dly = rise_dly_q;
   assign bus.fall_dly = fall_dly_q;
   assign bus.rise_vld = rise_vld_q;
   assign bus.fall_vld = fall_vld_q;
   assign bus.timeout  = timeout_q;
   assign bus.abort    = abort_q;
`ifdef GATE_DELAY_MINMAX_EN
   assign bus.min_rise = min_rise_q;
   assign bus.max_rise = max_rise_q;
   assign bus.min_fall = min_fall_q;
   assign bus.max_fall = max_fall_q;
`endif

endmodule
